// File: rtl/wb_gpio_irq_regs.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_irq_regs
// Brief    : Wishbone GPIO register file with banked outputs, atomic set/clear,
//            input synchronisers and per-pin edge interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module wb_gpio_irq_regs #(
    parameter int                    ADDRWIDTH     = 7,
    parameter int                    GPIO_WIDTH    = 46,
    parameter int                    SYNC_STAGES   = 2,
    parameter logic [31:0]           DEVICE_ID     = 32'hCE1A0002,
    parameter logic [31:0]           DEF_REG_VALUE = 32'hFABDEFAC,
    parameter logic [GPIO_WIDTH-1:0] OUT_RST       = '0,
    parameter logic [GPIO_WIDTH-1:0] OE_RST        = '0
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_n_i,
    input  logic [ADDRWIDTH-1:0]  WBs_ADR_i,
    input  logic                  WBs_CYC_i,
    input  logic                  WBs_STB_i,
    input  logic                  WBs_WE_i,
    input  logic [3:0]            WBs_BYTE_STB_i,
    input  logic [31:0]           WBs_DAT_i,
    output logic [31:0]           WBs_DAT_o,
    output logic                  WBs_ACK_o,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN_i,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT_o,
    output logic [GPIO_WIDTH-1:0] GPIO_OE_o,
    output logic                  IRQ_o
);

    localparam int              c_nb   = (GPIO_WIDTH + 31) / 32;
    localparam int              c_pw   = c_nb * 32;
    localparam logic [c_pw-1:0] c_mask = c_pw'({GPIO_WIDTH{1'b1}});

    localparam logic [3:0] c_grp_sys  = 4'h0;
    localparam logic [3:0] c_grp_in   = 4'h1;
    localparam logic [3:0] c_grp_out  = 4'h2;
    localparam logic [3:0] c_grp_set  = 4'h3;
    localparam logic [3:0] c_grp_clr  = 4'h4;
    localparam logic [3:0] c_grp_oe   = 4'h5;
    localparam logic [3:0] c_grp_rise = 4'h6;
    localparam logic [3:0] c_grp_fall = 4'h7;
    localparam logic [3:0] c_grp_stat = 4'h8;

    // Registers are held at full bank width; bits above GPIO_WIDTH stay 0.
    logic            r_ack, r_ie, r_irq;
    logic [c_pw-1:0] r_out, r_oe, r_rise_en, r_fall_en, r_stat, r_prev;
    logic [c_pw-1:0] r_sync [SYNC_STAGES];

    logic [c_pw-1:0] w_pad_in, w_sync, w_edge, w_lane, w_wdat, w_wbits, w_stat_nxt;
    logic [31:0]     w_be32, w_rdat;
    logic [31:0]     w_b_in, w_b_out, w_b_oe, w_b_rise, w_b_fall, w_b_stat;
    logic [3:0]      w_grp;
    logic [2:0]      w_bank;
    logic            w_adr_ok, w_wr, w_bank_ok, w_wr_ctrl, w_ie_nxt;

    generate
        if (ADDRWIDTH > 7) begin : g_adr_hi
            assign w_adr_ok = ~|WBs_ADR_i[ADDRWIDTH-1:7];
        end else begin : g_adr_lo
            assign w_adr_ok = 1'b1;
        end
    endgenerate

    assign w_grp    = WBs_ADR_i[6:3];
    assign w_bank   = WBs_ADR_i[2:0];
    assign w_wr     = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~r_ack;
    assign w_be32   = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                       {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};
    assign w_wdat   = {c_nb{WBs_DAT_i}};
    assign w_wbits  = w_wdat & w_lane & c_mask;
    assign w_pad_in = c_pw'(GPIO_IN_i);
    assign w_sync   = r_sync[SYNC_STAGES-1];

    assign w_wr_ctrl = w_wr & w_adr_ok & (WBs_ADR_i[6:0] == 7'h01) & WBs_BYTE_STB_i[0];
    assign w_ie_nxt  = w_wr_ctrl ? WBs_DAT_i[0] : r_ie;

    // A new edge in the same cycle as a W1C wins over the clear.
    assign w_edge     = ((w_sync & ~r_prev & r_rise_en) | (~w_sync & r_prev & r_fall_en)) & c_mask;
    assign w_stat_nxt = (r_stat & ~((w_wr && w_grp == c_grp_stat) ? w_wbits : '0)) | w_edge;

    // Byte-lane enables land only in the addressed bank; banks >= c_nb match nothing.
    always_comb begin
        w_lane = '0;
        for (int b = 0; b < c_nb; b++) begin
            if (w_adr_ok && int'(w_bank) == b) w_lane[b*32 +: 32] = w_be32;
        end
    end

    always_comb begin
        w_bank_ok = 1'b0;
        w_b_in    = '0;
        w_b_out   = '0;
        w_b_oe    = '0;
        w_b_rise  = '0;
        w_b_fall  = '0;
        w_b_stat  = '0;
        for (int b = 0; b < c_nb; b++) begin
            if (int'(w_bank) == b) begin
                w_bank_ok = 1'b1;
                w_b_in    = w_sync[b*32 +: 32];
                w_b_out   = r_out[b*32 +: 32];
                w_b_oe    = r_oe[b*32 +: 32];
                w_b_rise  = r_rise_en[b*32 +: 32];
                w_b_fall  = r_fall_en[b*32 +: 32];
                w_b_stat  = r_stat[b*32 +: 32];
            end
        end
    end

    always_comb begin
        w_rdat = DEF_REG_VALUE;
        if (w_adr_ok) begin
            case (w_grp)
                c_grp_sys: begin
                    if (w_bank == 3'd0)      w_rdat = DEVICE_ID;
                    else if (w_bank == 3'd1) w_rdat = {31'd0, r_ie};
                end
                c_grp_in:   if (w_bank_ok) w_rdat = w_b_in;
                c_grp_out:  if (w_bank_ok) w_rdat = w_b_out;
                c_grp_set,
                c_grp_clr:  if (w_bank_ok) w_rdat = 32'd0;
                c_grp_oe:   if (w_bank_ok) w_rdat = w_b_oe;
                c_grp_rise: if (w_bank_ok) w_rdat = w_b_rise;
                c_grp_fall: if (w_bank_ok) w_rdat = w_b_fall;
                c_grp_stat: if (w_bank_ok) w_rdat = w_b_stat;
                default:    w_rdat = DEF_REG_VALUE;
            endcase
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            r_ack     <= 1'b0;
            r_ie      <= 1'b0;
            r_irq     <= 1'b0;
            r_out     <= c_pw'(OUT_RST);
            r_oe      <= c_pw'(OE_RST);
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_stat    <= '0;
            r_prev    <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_ack     <= WBs_CYC_i & WBs_STB_i & ~r_ack;
            r_ie      <= w_ie_nxt;
            r_stat    <= w_stat_nxt;
            r_irq     <= w_ie_nxt & |w_stat_nxt;
            r_prev    <= w_sync;
            r_sync[0] <= w_pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            if (w_wr) begin
                case (w_grp)
                    c_grp_out:  r_out     <= (r_out & ~(w_lane & c_mask)) | w_wbits;
                    c_grp_set:  r_out     <= r_out | w_wbits;
                    c_grp_clr:  r_out     <= r_out & ~w_wbits;
                    c_grp_oe:   r_oe      <= (r_oe & ~(w_lane & c_mask)) | w_wbits;
                    c_grp_rise: r_rise_en <= (r_rise_en & ~(w_lane & c_mask)) | w_wbits;
                    c_grp_fall: r_fall_en <= (r_fall_en & ~(w_lane & c_mask)) | w_wbits;
                    default: ;
                endcase
            end
        end
    end

    assign WBs_DAT_o  = w_rdat;
    assign WBs_ACK_o  = r_ack;
    assign GPIO_OUT_o = r_out[GPIO_WIDTH-1:0];
    assign GPIO_OE_o  = r_oe[GPIO_WIDTH-1:0];
    assign IRQ_o      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_irq_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_gpio_irq_regs
// Brief    : Directed self-checking bench for wb_gpio_irq_regs (46 pins).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_gpio_irq_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  adr = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack;
    logic [45:0] gpio_in = '0;
    logic [45:0] gpio_out, gpio_oe;
    logic        irq;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [31:0] rd;

    wb_gpio_irq_regs dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_n_i    (rst_n),
        .WBs_ADR_i      (adr),
        .WBs_CYC_i      (cyc),
        .WBs_STB_i      (stb),
        .WBs_WE_i       (we),
        .WBs_BYTE_STB_i (be),
        .WBs_DAT_i      (dat_i),
        .WBs_DAT_o      (dat_o),
        .WBs_ACK_o      (ack),
        .GPIO_IN_i      (gpio_in),
        .GPIO_OUT_o     (gpio_out),
        .GPIO_OE_o      (gpio_oe),
        .IRQ_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after a falling edge; returns right after a falling edge.
    task automatic xfer(input logic w, input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] r);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; be = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check("ack_latency", 64'(n), 64'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 64'(ack), 64'd0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        xfer(1'b1, a, d, b, r);
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, 4'hF, r);
        check(tag, 64'(r), 64'(exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle(3);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_out", 64'(gpio_out), 64'd0);
        check("rst_oe",  64'(gpio_oe),  64'd0);
        rst_n = 1'b1;
        idle(2);
        rd_chk("id",      7'h00, 32'hCE1A0002);
        rd_chk("out0_rst", 7'h10, 32'h0);
        rd_chk("unmapped", 7'h7F, 32'hFABDEFAC);

        // Byte-lane write, then atomic set / clear
        wr(7'h10, 32'hFFFF_0000, 4'b0100);
        check("out_byte2", 64'(gpio_out[31:0]), 64'h00FF_0000);
        wr(7'h18, 32'h0000_0001, 4'hF);
        check("out_set", 64'(gpio_out[31:0]), 64'h00FF_0001);
        wr(7'h20, 32'h0001_0000, 4'hF);
        check("out_clr", 64'(gpio_out[31:0]), 64'h00FE_0001);
        rd_chk("out0_rd", 7'h10, 32'h00FE_0001);
        rd_chk("set_reads0", 7'h18, 32'h0);

        // Partial upper bank and nonexistent bank
        wr(7'h11, 32'hFFFF_FFFF, 4'hF);
        check("out_hi", 64'(gpio_out[45:32]), 64'h3FFF);
        check("out_lo_kept", 64'(gpio_out[31:0]), 64'h00FE_0001);
        rd_chk("out1_rd", 7'h11, 32'h0000_3FFF);
        rd_chk("bank2", 7'h12, 32'hFABDEFAC);
        wr(7'h28, 32'h0000_00A5, 4'hF);
        check("oe", 64'(gpio_oe), 64'h00A5);

        // Rising edge interrupt on pin 0
        wr(7'h30, 32'h1, 4'hF);
        wr(7'h01, 32'h1, 4'hF);
        rd_chk("ctrl", 7'h01, 32'h1);
        gpio_in[0] = 1'b1;
        @(negedge clk);
        check("irq_e1", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_e2", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_e3", 64'(irq), 64'd1);
        rd_chk("stat_rise", 7'h40, 32'h1);
        rd_chk("in0", 7'h08, 32'h1);
        wr(7'h40, 32'h1, 4'hF);
        check("irq_w1c", 64'(irq), 64'd0);
        rd_chk("stat_clr", 7'h40, 32'h0);
        gpio_in[0] = 1'b0;
        idle(5);
        check("no_fall_en0", 64'(irq), 64'd0);

        // Falling edge on pin 5 coinciding with its W1C
        wr(7'h38, 32'h20, 4'hF);
        gpio_in[5] = 1'b1;
        idle(5);
        check("no_rise_en5", 64'(irq), 64'd0);
        gpio_in[5] = 1'b0;
        idle(4);
        check("fall5_irq", 64'(irq), 64'd1);
        gpio_in[5] = 1'b1;
        idle(5);
        gpio_in[5] = 1'b0;
        idle(2);
        wr(7'h40, 32'h20, 4'hF);
        check("set_wins_irq", 64'(irq), 64'd1);
        rd_chk("set_wins_stat", 7'h40, 32'h20);
        rd_chk("stat_bank1", 7'h41, 32'h0);
        wr(7'h40, 32'h20, 4'hF);
        rd_chk("stat5_clr", 7'h40, 32'h0);
        check("irq_clr5", 64'(irq), 64'd0);

        // Asynchronous reset in the middle of a write
        gpio_in[0] = 1'b1;
        idle(4);
        check("irq_pre_rst", 64'(irq), 64'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h10; dat_i = 32'h1234_5678; be = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 64'(ack), 64'd0);
        check("rst_mid_irq", 64'(irq), 64'd0);
        check("rst_mid_out", 64'(gpio_out), 64'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("rst_hold_ack", 64'(ack), 64'd0);
        check("rst_hold_out", 64'(gpio_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("post_rst_out", 7'h10, 32'h0);
        rd_chk("post_rst_ctrl", 7'h01, 32'h0);
        rd_chk("post_rst_rise", 7'h30, 32'h0);
        wr(7'h10, 32'h0000_0055, 4'hF);
        rd_chk("post_rst_wr", 7'h10, 32'h0000_0055);
        rd_chk("post_rst_stat", 7'h40, 32'h0);
        check("post_rst_irq", 64'(irq), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
